chip_7420_emu: RTL
==================

Name: chip_7420_emu

Overview:
- Behavioural stand-in for a physical 7420 (dual 4-input NAND) on the socket side of the chip-checker pin interface.
- Receives the tester-driven input pins and drives the two output pins (Pin6, Pin8).
- Adds selectable fault injection, so checker FSMs can be exercised against known-good and known-bad parts without hardware.
- Tracks input-vector coverage and vector activity, so a bench can confirm that the tester swept all 16 combinations per gate.

Parameters:
- LATENCY, 0, output register stages between NAND evaluation and Pin6/Pin8. Legal values 0..3; 0 = combinational path.
- LFSR_SEED, 16'hACE1, reset value of the intermittent-fault LFSR. Must be nonzero.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- Pin1  input  1  gate A input A
- Pin2  input  1  gate A input B
- Pin4  input  1  gate A input C
- Pin5  input  1  gate A input D
- Pin13  input  1  gate B input A
- Pin12  input  1  gate B input B
- Pin10  input  1  gate B input C
- Pin9  input  1  gate B input D
- Pin6  output  1  gate A output
- Pin8  output  1  gate B output
- Fault_Mode  input  3  fault type (see Behaviour)
- Fault_Gate  input  2  fault target mask: bit0 = gate A, bit1 = gate B
- Clr_Cov  input  1  synchronous clear of coverage and vector count
- Cov_A  output  16  gate A coverage bitmap, indexed by {Pin5,Pin4,Pin2,Pin1}
- Cov_B  output  16  gate B coverage bitmap, indexed by {Pin9,Pin10,Pin12,Pin13}
- Cov_Done  output  1  high when Cov_A and Cov_B are both all-ones
- Vec_Count  output  8  count of input-vector changes, saturating at 255

Behaviour:
- Nominal output per gate: Y = ~(A & B & C & D).
- The fault transform applies only to gates selected in Fault_Gate. Unselected gates, and undefined modes, pass nominal Y.
  - 000: none.
  - 001: stuck-at-0.
  - 010: stuck-at-1.
  - 011: inverted output (AND behaviour).
  - 100: intermittent; Y inverted when lfsr[0] = 1.
  - 101: input D open (read as 1), so Y = ~(A & B & C).
  - 110, 111: none.
- Fault_Mode and Fault_Gate are applied combinationally to the evaluation stage. A mode change affects the output that stage produces that same cycle.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every non-reset cycle. Loads LFSR_SEED on Reset.
- LATENCY = 0: Pin6/Pin8 are combinational functions of the pins, faults and lfsr.
- LATENCY = N > 0: the faulted Y passes through N flops. A change on an input pin at cycle t appears on the output at edge t+N.
- Reset values:
  - All pipeline flops = 1 (NAND of all-zero inputs), so Pin6 = Pin8 = 1 for N cycles after Reset releases when N > 0.
  - Cov_A = Cov_B = 0, Cov_Done = 0, Vec_Count = 0.
  - Previous-vector register = 8'h00.
  - lfsr = LFSR_SEED.
- Coverage: on every non-reset edge, set Cov_A[{Pin5,Pin4,Pin2,Pin1}] and Cov_B[{Pin9,Pin10,Pin12,Pin13}].
  - Bits are sticky until Reset or Clr_Cov.
  - Clr_Cov wins over a same-cycle set: the bitmaps are 0 after that edge, and the current vector is not recorded.
- Cov_Done = (&Cov_A) & (&Cov_B), decoded from registered state (one cycle after the final bit is set).
- Vec_Count:
  - Increments on an edge where the current 8-bit pin vector differs from the previous-vector register.
  - Saturates at 255.
  - The previous-vector register updates every non-reset edge, including when Clr_Cov is asserted.
  - Clr_Cov zeroes Vec_Count and suppresses that edge's increment.
- Reset mid-sweep: all state is lost, and the pipeline returns to 1s on the same edge.
- No handshake: the block is a pure responder and never back-pressures the tester.

Test Plan:
- LATENCY=0, Fault_Mode=000: drive gate A inputs 0..15, one vector per cycle, gate B mirroring A -> Pin6 = Pin8 = 1 except vector 15, where both are 0. After the sweep, Cov_A = Cov_B = 16'hFFFF, Cov_Done = 1 one cycle after the last vector, Vec_Count = 15.
- Fault_Mode=001, Fault_Gate=01, all inputs 0 -> Pin6 = 0, Pin8 = 1. Change to Fault_Gate=10 -> Pin6 = 1, Pin8 = 0 in the same cycle.
- Fault_Mode=101 on gate A, inputs A=B=C=1, D=0 -> Pin6 = 0 (nominal would be 1). Gate B with the same inputs -> Pin8 = 1.
- LATENCY=2, all inputs 1 applied at the first cycle after Reset -> Pin6/Pin8 stay 1 for 2 edges, then 0 from the second edge onward.
- Fault_Mode=100, inputs constant 0, 32 cycles -> Pin6 toggles with lfsr[0], and the sequence matches a reference LFSR from seed 16'hACE1. Vec_Count stays 0.
- Mid-sweep at vector 7, assert Clr_Cov for one cycle -> Cov_A = 0, Vec_Count = 0 after that edge. The next changed vector sets exactly one Cov_A bit and gives Vec_Count = 1. Reset asserted mid-sweep -> all outputs return to reset values on that edge.

Source files
------------

// File: rtl/chip_7420_emu.sv
// Behavioural dual 4-input NAND (7420) socket emulator with fault
// injection, optional output latency and input-vector coverage tracking.
module chip_7420_emu #(
   parameter int          LATENCY   = 0,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Pin1,
   input  logic        Pin2,
   input  logic        Pin4,
   input  logic        Pin5,
   input  logic        Pin13,
   input  logic        Pin12,
   input  logic        Pin10,
   input  logic        Pin9,
   output logic        Pin6,
   output logic        Pin8,
   input  logic [2:0]  Fault_Mode,
   input  logic [1:0]  Fault_Gate,
   input  logic        Clr_Cov,
   output logic [15:0] Cov_A,
   output logic [15:0] Cov_B,
   output logic        Cov_Done,
   output logic [7:0]  Vec_Count
);

   logic [3:0]  vec_a;
   logic [3:0]  vec_b;
   logic [7:0]  vec_cur;
   logic [7:0]  vec_prev;
   logic [15:0] lfsr;
   logic        lfsr_fb;
   logic        y_a;
   logic        y_b;

   assign vec_a   = {Pin5, Pin4, Pin2, Pin1};
   assign vec_b   = {Pin9, Pin10, Pin12, Pin13};
   assign vec_cur = {vec_b, vec_a};
   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

   // Index 3 of each vector is the D input of that gate.
   function automatic logic fault_y(
      input logic [3:0] v,
      input logic [2:0] mode,
      input logic       sel,
      input logic       rnd
   );
      logic nom;
      logic y;
      nom = ~&v;
      y   = nom;
      if (sel) begin
         case (mode)
            3'b001:  y = 1'b0;
            3'b010:  y = 1'b1;
            3'b011:  y = ~nom;
            3'b100:  y = nom ^ rnd;
            3'b101:  y = ~&v[2:0];
            default: y = nom;
         endcase
      end
      return y;
   endfunction

   always_comb begin
      y_a = fault_y(vec_a, Fault_Mode, Fault_Gate[0], lfsr[0]);
      y_b = fault_y(vec_b, Fault_Mode, Fault_Gate[1], lfsr[0]);
   end

   generate
      if (LATENCY == 0) begin : g_comb
         assign Pin6 = y_a;
         assign Pin8 = y_b;
      end else begin : g_pipe
         logic [LATENCY-1:0] pipe_a;
         logic [LATENCY-1:0] pipe_b;

         always_ff @(posedge Clk) begin
            if (Reset) begin
               pipe_a <= '1;
               pipe_b <= '1;
            end else begin
               pipe_a <= (pipe_a << 1) | LATENCY'(y_a);
               pipe_b <= (pipe_b << 1) | LATENCY'(y_b);
            end
         end

         assign Pin6 = pipe_a[LATENCY-1];
         assign Pin8 = pipe_b[LATENCY-1];
      end
   endgenerate

   always_ff @(posedge Clk) begin
      if (Reset) begin
         lfsr      <= LFSR_SEED;
         vec_prev  <= 8'h00;
         Cov_A     <= 16'h0000;
         Cov_B     <= 16'h0000;
         Vec_Count <= 8'h00;
      end else begin
         lfsr     <= {lfsr_fb, lfsr[15:1]};
         vec_prev <= vec_cur;
         if (Clr_Cov) begin
            Cov_A     <= 16'h0000;
            Cov_B     <= 16'h0000;
            Vec_Count <= 8'h00;
         end else begin
            Cov_A <= Cov_A | (16'h0001 << vec_a);
            Cov_B <= Cov_B | (16'h0001 << vec_b);
            if (vec_cur != vec_prev && Vec_Count != 8'hFF)
               Vec_Count <= Vec_Count + 8'h01;
         end
      end
   end

   assign Cov_Done = (&Cov_A) & (&Cov_B);

endmodule
